// File: rtl/fp_norm_pack_if.sv
// fp_norm_pack_if: handshake bundle for the FP adder post-ALU normaliser.
// The master side produces ALU results and consumes packed words; the slave
// side is the normaliser itself.
interface fp_norm_pack_if #(
   parameter int MANT_W = 23,
   parameter int EXP_W  = 8
);
   logic                     inValid;
   logic                     inReady;
   logic                     inSign;
   logic [EXP_W-1:0]         inExp;
   logic [MANT_W:0]          inMantissa;
   logic                     inCarry;
   logic                     outValid;
   logic                     outReady;
   logic [EXP_W+MANT_W:0]    outResult;
   logic                     outZero;
   logic                     outOverflow;

   modport master (
      output inValid, inSign, inExp, inMantissa, inCarry, outReady,
      input  inReady, outValid, outResult, outZero, outOverflow
   );

   modport slave (
      input  inValid, inSign, inExp, inMantissa, inCarry, outReady,
      output inReady, outValid, outResult, outZero, outOverflow
   );
endinterface

// File: rtl/fp_norm_pack.sv
// fp_norm_pack: renormalises the sign-magnitude ALU result of the FP adder
// and packs it into an IEEE-754 style {sign, exp, fraction} word.
// Carry-out is handled with a single right shift at acceptance; cancellation
// is handled by shifting left up to SHIFT_STEP places per cycle.
// Truncation only, no rounding.
// Optional build macro FP_NORM_DENORM_EN: underflow produces a denormal
// instead of flushing to signed zero.
module fp_norm_pack #(
   parameter int MANT_W     = 23,
   parameter int EXP_W      = 8,
   parameter int SHIFT_STEP = 1
) (
   input logic            clk,
   input logic            rstN,
   fp_norm_pack_if.slave  bus
);

   localparam int SH_W = $clog2(MANT_W + 2);
   localparam int XW   = EXP_W + 2;
   localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
   localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
   localparam logic [SH_W-1:0]      STEP_V  = SH_W'(SHIFT_STEP);

   typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
   typedef enum logic [1:0] {K_NORMAL, K_ZERO, K_OVF, K_DEN} kind_t;

   state_t                 state_q, state_nxt;
   kind_t                  kind_p0, kind_nxt;
   logic                   sign_p0, sign_nxt;
   logic signed [XW-1:0]   exp_p0, exp_nxt;
   logic [MANT_W:0]        mant_p0, mant_nxt;

   logic [SH_W-1:0]        lz, step;
   logic signed [XW-1:0]   step_x, exp_dec, exp_in;
   logic                   accept;

   logic [EXP_W+MANT_W:0]  pack_res, res_p1;
   logic                   pack_zero, pack_ovf;
   logic                   vld_p1, zero_p1, ovf_p1;

`ifdef FP_NORM_DENORM_EN
   logic signed [XW-1:0]   exp_gap;
   assign exp_gap = exp_p0 - EXP_ONE;
`endif

   function automatic logic [SH_W-1:0] lead_zeros(input logic [MANT_W:0] m);
      logic [SH_W-1:0] n;
      logic            found;
      n     = '0;
      found = 1'b0;
      for (int i = MANT_W; i >= 0; i--) begin
         if (!found && !m[i]) n = n + SH_W'(1);
         else found = 1'b1;
      end
      return n;
   endfunction

   assign lz      = lead_zeros(mant_p0);
   assign step    = (lz < STEP_V) ? lz : STEP_V;
   assign step_x  = $signed({{(XW-SH_W){1'b0}}, step});
   assign exp_dec = exp_p0 - step_x;
   assign exp_in  = $signed({2'b00, bus.inExp}) + EXP_ONE;

   assign bus.inReady     = rstN && (state_q == IDLE);
   assign accept          = bus.inValid && bus.inReady;
   assign bus.outValid    = vld_p1;
   assign bus.outResult   = res_p1;
   assign bus.outZero     = zero_p1;
   assign bus.outOverflow = ovf_p1;

   // Next-state and working-register update: accept, normalise, wait for drain
   always_comb begin
      state_nxt = state_q;
      kind_nxt  = kind_p0;
      sign_nxt  = sign_p0;
      exp_nxt   = exp_p0;
      mant_nxt  = mant_p0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               sign_nxt = bus.inSign;
               kind_nxt = K_NORMAL;
               if (bus.inCarry) begin
                  mant_nxt  = {1'b1, bus.inMantissa[MANT_W:1]};
                  exp_nxt   = exp_in;
                  state_nxt = DONE;
                  if (exp_in >= EXP_MAX) kind_nxt = K_OVF;
               end else if (bus.inMantissa == '0) begin
                  sign_nxt  = 1'b0;
                  kind_nxt  = K_ZERO;
                  state_nxt = DONE;
               end else begin
                  mant_nxt  = bus.inMantissa;
                  exp_nxt   = $signed({2'b00, bus.inExp});
                  state_nxt = NORM;
               end
            end
         end
         NORM: begin
            if (mant_p0[MANT_W]) begin
               state_nxt = DONE;
            end else if (exp_dec < EXP_ONE) begin
`ifdef FP_NORM_DENORM_EN
               // Stop at the smallest normal exponent and emit a denormal
               if (exp_p0 <= EXP_ONE) begin
                  kind_nxt  = K_DEN;
                  state_nxt = DONE;
               end else begin
                  mant_nxt = mant_p0 << exp_gap;
                  exp_nxt  = EXP_ONE;
               end
`else
               kind_nxt  = K_ZERO;
               state_nxt = DONE;
`endif
            end else begin
               mant_nxt = mant_p0 << step;
               exp_nxt  = exp_dec;
            end
         end
         DONE: begin
            if (vld_p1 && bus.outReady) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pack the working registers into the output word for the result kind
   always_comb begin
      pack_res  = {sign_p0, exp_p0[EXP_W-1:0], mant_p0[MANT_W-1:0]};
      pack_zero = 1'b0;
      pack_ovf  = 1'b0;
      case (kind_p0)
         K_OVF: begin
            pack_res = {sign_p0, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            pack_ovf = 1'b1;
         end
         K_ZERO: begin
            pack_res  = {sign_p0, {(EXP_W+MANT_W){1'b0}}};
            pack_zero = 1'b1;
         end
         K_DEN: begin
            pack_res  = {sign_p0, {EXP_W{1'b0}}, mant_p0[MANT_W-1:0]};
            pack_zero = (mant_p0[MANT_W-1:0] == '0);
         end
         default: ;
      endcase
   end

   // Control state: FSM and result kind
   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q <= IDLE;
         kind_p0 <= K_NORMAL;
      end else begin
         state_q <= state_nxt;
         kind_p0 <= kind_nxt;
      end
   end

   // Working datapath: sign, widened exponent and mantissa under normalisation
   always_ff @(posedge clk) begin
      sign_p0 <= sign_nxt;
      exp_p0  <= exp_nxt;
      mant_p0 <= mant_nxt;
   end

   // Output stage: load once on entering DONE, hold until the downstream takes it
   always_ff @(posedge clk) begin
      if (!rstN) begin
         vld_p1  <= 1'b0;
         res_p1  <= '0;
         zero_p1 <= 1'b0;
         ovf_p1  <= 1'b0;
      end else if (state_q == DONE && !vld_p1) begin
         vld_p1  <= 1'b1;
         res_p1  <= pack_res;
         zero_p1 <= pack_zero;
         ovf_p1  <= pack_ovf;
      end else if (vld_p1 && bus.outReady) begin
         vld_p1  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fp_norm_pack.sv
// tb_fp_norm_pack: directed vectors for fp_norm_pack, run on two instances
// (SHIFT_STEP 1 and 8) sharing one input stream. Expected values follow the
// FP_NORM_DENORM_EN macro when the bench is built with it.
module tb_fp_norm_pack;
   localparam int MW = 23;
   localparam int EW = 8;

   logic clk;
   logic rstN;

   fp_norm_pack_if #(.MANT_W(MW), .EXP_W(EW)) bus ();
   fp_norm_pack_if #(.MANT_W(MW), .EXP_W(EW)) bus8 ();

   fp_norm_pack #(.MANT_W(MW), .EXP_W(EW), .SHIFT_STEP(1)) u_dut (
      .clk(clk), .rstN(rstN), .bus(bus));
   fp_norm_pack #(.MANT_W(MW), .EXP_W(EW), .SHIFT_STEP(8)) u_dut8 (
      .clk(clk), .rstN(rstN), .bus(bus8));

   assign bus8.inValid    = bus.inValid;
   assign bus8.inSign     = bus.inSign;
   assign bus8.inExp      = bus.inExp;
   assign bus8.inMantissa = bus.inMantissa;
   assign bus8.inCarry    = bus.inCarry;
   assign bus8.outReady   = bus.outReady;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        s;
      logic [7:0]  e;
      logic [23:0] m;
      logic        c;
      logic [31:0] res;
      logic        z;
      logic        o;
      int          lat1;
      int          lat8;
   } vec_t;

   vec_t vecs [12];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int          lat1 = -1;
      int          lat8 = -1;
      logic [31:0] r1 = '0;
      logic [31:0] r8 = '0;
      logic        z1 = 1'b0, o1 = 1'b0, z8 = 1'b0, o8 = 1'b0;
      bit          g1 = 1'b0, g8 = 1'b0;
      @(negedge clk);
      bus.inSign     = v.s;
      bus.inExp      = v.e;
      bus.inMantissa = v.m;
      bus.inCarry    = v.c;
      bus.inValid    = 1'b1;
      chk($sformatf("v%0d_inready", idx), 32'({bus.inReady, bus8.inReady}), 32'd3);
      @(posedge clk);
      @(negedge clk);
      bus.inValid = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (!g1 && bus.outValid) begin
            g1 = 1'b1; lat1 = c; r1 = bus.outResult; z1 = bus.outZero; o1 = bus.outOverflow;
         end
         if (!g8 && bus8.outValid) begin
            g8 = 1'b1; lat8 = c; r8 = bus8.outResult; z8 = bus8.outZero; o8 = bus8.outOverflow;
         end
         if (g1 && g8) break;
      end
      chk($sformatf("v%0d_res_s1", idx), r1, v.res);
      chk($sformatf("v%0d_zero_s1", idx), 32'(z1), 32'(v.z));
      chk($sformatf("v%0d_ovf_s1", idx), 32'(o1), 32'(v.o));
      chk($sformatf("v%0d_lat_s1", idx), 32'(lat1), 32'(v.lat1));
      chk($sformatf("v%0d_res_s8", idx), r8, v.res);
      chk($sformatf("v%0d_zero_s8", idx), 32'(z8), 32'(v.z));
      chk($sformatf("v%0d_ovf_s8", idx), 32'(o8), 32'(v.o));
      chk($sformatf("v%0d_lat_s8", idx), 32'(lat8), 32'(v.lat8));
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_valid_drop", idx), 32'({bus.outValid, bus8.outValid}), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      vecs[0]  = '{1'b0, 8'h80, 24'hC40000, 1'b0, 32'h40440000, 1'b0, 1'b0, 2, 2};
      vecs[1]  = '{1'b0, 8'h7F, 24'h342000, 1'b1, 32'h401A1000, 1'b0, 1'b0, 1, 1};
      vecs[2]  = '{1'b0, 8'h80, 24'h000001, 1'b0, 32'h34800000, 1'b0, 1'b0, 25, 5};
      vecs[3]  = '{1'b1, 8'h55, 24'h000000, 1'b0, 32'h00000000, 1'b1, 1'b0, 1, 1};
      vecs[4]  = '{1'b0, 8'hFE, 24'h400000, 1'b1, 32'h7F800000, 1'b0, 1'b1, 1, 1};
      vecs[5]  = '{1'b1, 8'hFF, 24'h123456, 1'b1, 32'hFF800000, 1'b0, 1'b1, 1, 1};
      vecs[6]  = '{1'b0, 8'hFD, 24'h000000, 1'b1, 32'h7F000000, 1'b0, 1'b0, 1, 1};
      vecs[7]  = '{1'b1, 8'h85, 24'h0F0000, 1'b0, 32'hC0F00000, 1'b0, 1'b0, 6, 3};
      vecs[8]  = '{1'b1, 8'h10, 24'hFFFFFF, 1'b1, 32'h88FFFFFF, 1'b0, 1'b0, 1, 1};
      vecs[9]  = '{1'b0, 8'h00, 24'h800001, 1'b0, 32'h00000001, 1'b0, 1'b0, 2, 2};
`ifdef FP_NORM_DENORM_EN
      vecs[10] = '{1'b0, 8'h02, 24'h100000, 1'b0, 32'h00200000, 1'b0, 1'b0, 3, 3};
      vecs[11] = '{1'b1, 8'h01, 24'h000001, 1'b0, 32'h80000001, 1'b0, 1'b0, 2, 2};
`else
      vecs[10] = '{1'b0, 8'h02, 24'h100000, 1'b0, 32'h00000000, 1'b1, 1'b0, 3, 2};
      vecs[11] = '{1'b1, 8'h01, 24'h000001, 1'b0, 32'h80000000, 1'b1, 1'b0, 2, 2};
`endif

      rstN           = 1'b0;
      bus.inValid    = 1'b0;
      bus.inSign     = 1'b0;
      bus.inExp      = '0;
      bus.inMantissa = '0;
      bus.inCarry    = 1'b0;
      bus.outReady   = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_outvalid", 32'({bus.outValid, bus8.outValid}), 32'd0);
      chk("rst_inready", 32'({bus.inReady, bus8.inReady}), 32'd0);
      chk("rst_result", bus.outResult, 32'h0);
      chk("rst_flags", 32'({bus.outZero, bus.outOverflow, bus8.outZero, bus8.outOverflow}), 32'd0);
      rstN = 1'b1;
      #1;
      chk("rst_release_inready", 32'({bus.inReady, bus8.inReady}), 32'd3);

      for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

      // Backpressure: result held while downstream stalls
      @(negedge clk);
      bus.outReady   = 1'b0;
      bus.inSign     = 1'b0;
      bus.inExp      = 8'h80;
      bus.inMantissa = 24'hC40000;
      bus.inCarry    = 1'b0;
      bus.inValid    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.inValid = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(posedge clk);
         @(negedge clk);
         seen = bus.outValid && bus8.outValid;
      end
      chk("bp_valid_rise", 32'(seen), 32'd1);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("bp_hold%0d_valid", c), 32'({bus.outValid, bus8.outValid}), 32'd3);
         chk($sformatf("bp_hold%0d_res", c), bus.outResult, 32'h40440000);
         chk($sformatf("bp_hold%0d_inready", c), 32'({bus.inReady, bus8.inReady}), 32'd0);
      end
      bus.outReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("bp_release_valid", 32'({bus.outValid, bus8.outValid}), 32'd0);
      chk("bp_release_inready", 32'({bus.inReady, bus8.inReady}), 32'd3);

      // Reset in the middle of a long normalisation discards the value
      bus.inSign     = 1'b0;
      bus.inExp      = 8'h80;
      bus.inMantissa = 24'h000001;
      bus.inCarry    = 1'b0;
      bus.inValid    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.inValid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rstN = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_outvalid", 32'({bus.outValid, bus8.outValid}), 32'd0);
      chk("midrst_inready", 32'({bus.inReady, bus8.inReady}), 32'd0);
      rstN = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.outValid || bus8.outValid) seen = 1'b1;
      end
      chk("midrst_no_output", 32'(seen), 32'd0);
      run_vec(100, vecs[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
